// File: rtl/mgnt_pkg.sv
// Shared types for the magnet pulse controller and its gate driver.
package mgnt_pkg;

    localparam int DATABUS_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        CHG_ON,
        DCHG_ON,
        DEAD,
        FLT
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_OVERLAP = 2'b01;
    localparam logic [1:0] FC_WDOG    = 2'b10;

endpackage

// File: rtl/mgnt_gate_driver.sv
// Charge/discharge gate driver with break-before-make dead time, on-time watchdog and sticky fault.
// Latency: one cycle from sampled request to gate; all outputs registered.
// Backpressure: none; requests arriving during dead time are held off, never queued.
module mgnt_gate_driver #(
    parameter int DATABUS_WIDTH = mgnt_pkg::DATABUS_WIDTH,
    parameter int DT_WIDTH      = 8
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     EN,
    input  logic                     CHG_IN,
    input  logic                     DCHG_IN,
    input  logic [DT_WIDTH-1:0]      DEADTIME,
    input  logic [DATABUS_WIDTH-1:0] MAX_ON,
    input  logic                     FAULT_CLR,
    output logic                     CHG_GATE,
    output logic                     DCHG_GATE,
    output logic                     BUSY,
    output logic                     FAULT,
    output logic [1:0]               FAULT_CODE
);

    import mgnt_pkg::*;

    state_t                   state, state_nxt;
    logic [DATABUS_WIDTH-1:0] on_cnt, on_nxt;
    logic [DT_WIDTH-1:0]      dt_cnt, dt_nxt;
    logic                     chg_nxt, dchg_nxt, busy_nxt, fault_nxt;
    logic [1:0]               code_nxt;
    logic                     own_req, other_req, eval_idle;

    always_comb begin
        state_nxt = state;
        on_nxt    = on_cnt;
        dt_nxt    = dt_cnt;
        chg_nxt   = 1'b0;
        dchg_nxt  = 1'b0;
        fault_nxt = FAULT;
        code_nxt  = FAULT_CODE;
        eval_idle = 1'b0;
        own_req   = (state == CHG_ON) ? CHG_IN  : DCHG_IN;
        other_req = (state == CHG_ON) ? DCHG_IN : CHG_IN;

        case (state)
            IDLE: eval_idle = 1'b1;
            CHG_ON, DCHG_ON: begin
                if (other_req) begin
                    state_nxt = FLT;
                    fault_nxt = 1'b1;
                    code_nxt  = FC_OVERLAP;
                end else if (MAX_ON != '0 && on_cnt == MAX_ON) begin
                    state_nxt = FLT;
                    fault_nxt = 1'b1;
                    code_nxt  = FC_WDOG;
                end else if (!own_req || !EN) begin
                    state_nxt = DEAD;
                    dt_nxt    = DEADTIME;
                end else begin
                    chg_nxt  = (state == CHG_ON);
                    dchg_nxt = (state == DCHG_ON);
                    // Saturate so a disabled watchdog never sees a wrapped count.
                    if (on_cnt != '1) begin
                        on_nxt = on_cnt + 1'b1;
                    end
                end
            end
            DEAD: begin
                if (dt_cnt != '0) begin
                    dt_nxt = dt_cnt - 1'b1;
                    if (CHG_IN && DCHG_IN) begin
                        state_nxt = FLT;
                        fault_nxt = 1'b1;
                        code_nxt  = FC_OVERLAP;
                    end
                end else begin
                    eval_idle = 1'b1;
                end
            end
            FLT: begin
                if (FAULT_CLR && !CHG_IN && !DCHG_IN) begin
                    state_nxt = DEAD;
                    dt_nxt    = DEADTIME;
                    fault_nxt = 1'b0;
                    code_nxt  = FC_NONE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Shared turn-on decision for IDLE and an expired DEAD window.
        if (eval_idle) begin
            if (CHG_IN && DCHG_IN) begin
                state_nxt = FLT;
                fault_nxt = 1'b1;
                code_nxt  = FC_OVERLAP;
            end else if (EN && CHG_IN) begin
                state_nxt = CHG_ON;
                chg_nxt   = 1'b1;
                on_nxt    = DATABUS_WIDTH'(1);
            end else if (EN && DCHG_IN) begin
                state_nxt = DCHG_ON;
                dchg_nxt  = 1'b1;
                on_nxt    = DATABUS_WIDTH'(1);
            end else begin
                state_nxt = IDLE;
            end
        end

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            on_cnt     <= '0;
            dt_cnt     <= '0;
            CHG_GATE   <= 1'b0;
            DCHG_GATE  <= 1'b0;
            BUSY       <= 1'b0;
            FAULT      <= 1'b0;
            FAULT_CODE <= FC_NONE;
        end else begin
            state      <= state_nxt;
            on_cnt     <= on_nxt;
            dt_cnt     <= dt_nxt;
            CHG_GATE   <= chg_nxt;
            DCHG_GATE  <= dchg_nxt;
            BUSY       <= busy_nxt;
            FAULT      <= fault_nxt;
            FAULT_CODE <= code_nxt;
        end
    end

endmodule

// File: tb/tb_mgnt_gate_driver.sv
// Scoreboard bench for mgnt_gate_driver: timestamp-based reference model feeds an expectation queue.
module tb_mgnt_gate_driver;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        EN = 1'b0;
    logic        CHG_IN = 1'b0;
    logic        DCHG_IN = 1'b0;
    logic [7:0]  DEADTIME = 8'd0;
    logic [31:0] MAX_ON = 32'd0;
    logic        FAULT_CLR = 1'b0;
    logic        CHG_GATE, DCHG_GATE, BUSY, FAULT;
    logic [1:0]  FAULT_CODE;

    mgnt_gate_driver dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .CHG_IN(CHG_IN), .DCHG_IN(DCHG_IN),
        .DEADTIME(DEADTIME), .MAX_ON(MAX_ON), .FAULT_CLR(FAULT_CLR),
        .CHG_GATE(CHG_GATE), .DCHG_GATE(DCHG_GATE), .BUSY(BUSY),
        .FAULT(FAULT), .FAULT_CODE(FAULT_CODE)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;
    logic [5:0] exp_q[$];

    // Reference model: which gate is on, how long, pending fault, and the
    // earliest edge index at which a gate may rise again.
    int         m_active = 0;
    longint     m_width = 0;
    logic [1:0] m_fault = 2'b00;
    int         m_n = 0;
    int         m_gap = 0;
    logic [7:0]  nxt_dt = 8'd0;
    logic [31:0] nxt_maxon = 32'd0;

    function automatic logic m_busy();
        return (m_fault != 2'b00) || (m_active != 0) || (m_n < m_gap);
    endfunction

    function automatic logic [5:0] model_vec();
        return {m_active == 1, m_active == 2, m_busy(), m_fault != 2'b00, m_fault};
    endfunction

    function automatic logic [5:0] dut_vec();
        return {CHG_GATE, DCHG_GATE, BUSY, FAULT, FAULT_CODE};
    endfunction

    function automatic void check(string name, logic [5:0] act, logic [5:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got chg=%b dchg=%b busy=%b fault=%b code=%b, want chg=%b dchg=%b busy=%b fault=%b code=%b",
                      name, $time, act[5], act[4], act[3], act[2], act[1:0],
                      exp[5], exp[4], exp[3], exp[2], exp[1:0]);
    endfunction

    function automatic void model_edge(logic en, logic c, logic d, logic clr);
        logic own, other;
        m_n++;
        if (m_fault != 2'b00) begin
            if (clr && !c && !d) begin
                m_fault = 2'b00;
                m_gap = m_n + int'(DEADTIME) + 1;
            end
        end else if (m_active != 0) begin
            own   = (m_active == 1) ? c : d;
            other = (m_active == 1) ? d : c;
            if (other) begin
                m_fault = 2'b01; m_active = 0;
            end else if (MAX_ON != 0 && m_width == longint'(MAX_ON)) begin
                m_fault = 2'b10; m_active = 0;
            end else if (!own || !en) begin
                m_active = 0;
                m_gap = m_n + int'(DEADTIME) + 1;
            end else begin
                m_width++;
            end
        end else if (c && d) begin
            m_fault = 2'b01;
        end else if (m_n >= m_gap) begin
            if (en && c) begin m_active = 1; m_width = 1; end
            else if (en && d) begin m_active = 2; m_width = 1; end
        end
    endfunction

    task automatic step(input logic en, input logic c, input logic d, input logic clr);
        @(negedge CLK);
        EN = en; CHG_IN = c; DCHG_IN = d; FAULT_CLR = clr;
        DEADTIME = nxt_dt; MAX_ON = nxt_maxon;
        model_edge(en, c, d, clr);
        exp_q.push_back(model_vec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_train();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        idle(12);
    endtask

    // Monitor: one expectation per clock edge, sampled 1 ns after the edge.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (RESET && exp_q.size() > 0) check("cycle", dut_vec(), exp_q.pop_front());
        end
    end

    initial begin
        logic c, d;
        #12;
        check("reset_state", dut_vec(), 6'b0);
        @(negedge CLK);
        RESET = 1'b1;

        // Controller-style trains with short and long dead time.
        nxt_dt = 8'd2; nxt_maxon = 32'd0;
        pulse_train();
        nxt_dt = 8'd6;
        pulse_train();

        // Watchdog trip, clear attempts with request high, then proper clear.
        nxt_dt = 8'd3; nxt_maxon = 32'd8;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(8);

        // Overlap during a charge pulse; clear is refused while DCHG_IN is high.
        nxt_maxon = 32'd0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(8);

        // EN dropped mid pulse, then a new request while disabled.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(8);

        // Asynchronous reset in the middle of a charge pulse.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        exp_q.delete();
        m_active = 0; m_fault = 2'b00; m_gap = 0;
        #1;
        check("async_reset_mid_pulse", dut_vec(), 6'b0);
        repeat (2) @(negedge CLK);
        CHG_IN = 1'b0;
        RESET = 1'b1;
        #1;
        check("after_reset_release", dut_vec(), 6'b0);
        idle(4);

        // Randomized request trains; timing parameters change only while idle.
        c = 1'b0; d = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!m_busy() && $urandom_range(0, 7) == 0) begin
                nxt_dt = 8'($urandom_range(0, 7));
                nxt_maxon = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 10));
            end
            if ($urandom_range(0, 5) == 0) c = ~c;
            if ($urandom_range(0, 7) == 0) begin
                d = ~d;
                if (d && c && $urandom_range(0, 9) != 0) d = 1'b0;
            end
            step($urandom_range(0, 19) != 0, c, d, $urandom_range(0, 3) == 0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(12);
        repeat (2) @(posedge CLK);
        #2;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mgnt_gate_driver.md
Name: mgnt_gate_driver

Overview:
- Downstream stage of the magnet pulse controller. Consumes its CHG_OUT/DCHG_OUT pulse trains and drives the charge and discharge power-switch gates.
- Enforces break-before-make dead time, a per-pulse maximum on-time watchdog and shoot-through protection.
- Any violation latches a sticky fault that holds both gates off until software clears it.

Parameters:
- DATABUS_WIDTH, 32, width of MAX_ON (matches controller parameter bus)
- DT_WIDTH, 8, width of DEADTIME counter

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous, active-low reset
- EN  input  1  driver enable; low forces gates off
- CHG_IN  input  1  charge request (from controller CHG_OUT)
- DCHG_IN  input  1  discharge request (from controller DCHG_OUT)
- DEADTIME  input  DT_WIDTH  extra off cycles between any gate fall and next gate rise
- MAX_ON  input  DATABUS_WIDTH  max gate-high cycles per pulse; 0 disables watchdog
- FAULT_CLR  input  1  fault clear request
- CHG_GATE  output  1  registered charge-switch gate
- DCHG_GATE  output  1  registered discharge-switch gate
- BUSY  output  1  high when state is not IDLE
- FAULT  output  1  sticky fault flag
- FAULT_CODE  output  2  00 none, 01 overlap (both requests high), 10 watchdog, 11 reserved

Behaviour:
- Reset (RESET=0, async): state IDLE; CHG_GATE=0, DCHG_GATE=0, BUSY=0, FAULT=0, FAULT_CODE=00; counters cleared.
- All outputs are registered. A request sampled at edge k changes the gate after edge k (1-cycle latency). Gates are never both high.
- States: IDLE, CHG_ON, DCHG_ON, DEAD, FLT.
- IDLE, all conditions evaluated in priority order:
  - CHG_IN&DCHG_IN -> FLT, code 01.
  - else EN&CHG_IN -> CHG_ON, CHG_GATE=1, on_cnt=1.
  - else EN&DCHG_IN -> DCHG_ON, DCHG_GATE=1, on_cnt=1.
  - else stay.
- CHG_ON, priority order:
  - DCHG_IN high -> FLT, code 01, gates 0.
  - else MAX_ON!=0 and on_cnt==MAX_ON -> FLT, code 10, gates 0. Gate-high width is therefore at most MAX_ON cycles.
  - else !CHG_IN or !EN -> DEAD, CHG_GATE=0, dt_cnt=DEADTIME.
  - else on_cnt+=1. on_cnt saturates at all-ones; it never wraps.
- DCHG_ON: mirror of CHG_ON with the roles of CHG and DCHG swapped.
- DEAD: gates 0.
  - If dt_cnt!=0: decrement. Requests are held off but still checked; CHG_IN&DCHG_IN -> FLT, code 01.
  - If dt_cnt==0: evaluate exactly as IDLE (may turn a gate on at this edge).
  - Result: minimum low gap between a gate fall and any gate rise is DEADTIME+1 cycles. DEADTIME=0 still gives a 1-cycle break.
- A request that stays high across DEAD is honoured late. The resulting pulse is shortened, because the gate still falls when the request falls.
- FLT: gates 0, FAULT=1, FAULT_CODE held. Exit to DEAD (dt_cnt=DEADTIME) only when FAULT_CLR=1 and CHG_IN=0 and DCHG_IN=0; FAULT/FAULT_CODE clear at that edge. FAULT_CLR outside FLT is ignored.
- EN low in IDLE/DEAD: no turn-on; no effect on fault detection.
- DEADTIME/MAX_ON are sampled live. Software changes them only while BUSY=0.
- Reset mid-pulse: gates drop asynchronously to 0 immediately.

Decomposition:
- Shared package mgnt_pkg holds:
  - the state enum (IDLE, CHG_ON, DCHG_ON, DEAD, FLT)
  - fault code constants (FC_NONE=2'b00, FC_OVERLAP=2'b01, FC_WDOG=2'b10)
  - DATABUS_WIDTH default 32, shared with the controller.
- Single module. The dead-time down-counter and on-time up-counter are inline; no sub-module is warranted.

Test Plan:
- Controller-style train with CHG_PLEN=3, CHG_DLEN=4, DCHG_PLEN=5, DEADTIME=2, MAX_ON=0:
  - CHG_GATE high 3 cycles, delayed 1 from CHG_IN.
  - DCHG_GATE high 5 cycles, delayed 1; no fault.
- Same train with DEADTIME=6:
  - DCHG_GATE rises 7 cycles after CHG_GATE falls.
  - DCHG_GATE is high only 2 cycles; FAULT=0.
- CHG_IN held high 20 cycles, MAX_ON=8:
  - CHG_GATE high exactly 8 cycles, then FAULT=1, FAULT_CODE=10.
  - Gates stay 0 until FAULT_CLR=1 with inputs low; then DEAD for DEADTIME cycles, then IDLE.
- DCHG_IN asserted during a CHG_ON pulse:
  - Next edge gives CHG_GATE=0, DCHG_GATE=0, FAULT_CODE=01.
  - FAULT_CLR while DCHG_IN is still high is ignored.
- EN dropped mid CHG pulse: CHG_GATE falls next edge, FSM enters DEAD; with EN low, a new CHG_IN gives no gate.
- RESET asserted asynchronously mid-pulse: gates drop before the next CLK edge; after release, all outputs are 0 and BUSY=0.
